// File: rtl/xmpl_fft_pkg.sv
// Shared types and default sizing for the FFT frame scheduler.
package xmpl_fft_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait,
    StUnload
  } state_e;

  localparam int unsigned DefNumReq   = 2;
  localparam int unsigned DefSampleW  = 16;
  localparam int unsigned DefFrameLen = 64;
  localparam int unsigned DefTimeout  = 1024;

endpackage

// File: rtl/xmpl_rr_arb.sv
// Combinational round-robin arbiter: picks the first request at or after ptr_i, wrapping.
module xmpl_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // First pass covers [ptr, NUM_REQ), second pass the wrapped part [0, ptr).
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[i] && (i >= 32'(ptr_i))) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[i] && (i < 32'(ptr_i))) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/xmpl_fft_sched.sv
// Shares one FFT core between NUM_REQ requesters, one whole frame at a time:
// arbitrate, stream samples in, wait for done (with timeout), stream results out.
module xmpl_fft_sched
  import xmpl_fft_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned SAMPLE_W  = DefSampleW,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned TIMEOUT   = DefTimeout,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  input  logic                in_valid_i,
  input  logic [SAMPLE_W-1:0] in_data_i,
  output logic                in_ready_o,
  output logic                fft_en_o,
  output logic                fft_start_o,
  output logic                fft_in_valid_o,
  output logic [SAMPLE_W-1:0] fft_in_data_o,
  input  logic                fft_done_i,
  input  logic                fft_out_valid_i,
  input  logic [SAMPLE_W-1:0] fft_out_data_i,
  output logic                fft_out_ready_o,
  output logic                out_valid_o,
  output logic [SAMPLE_W-1:0] out_data_o,
  output logic                out_last_o,
  output logic [ID_W-1:0]     out_id_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned BeatW = $clog2(FRAME_LEN);
  localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BeatW-1:0] BeatLast = BeatW'(FRAME_LEN - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  IdLast   = ID_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      winner_q, winner_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 start_q, start_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_valid;
  logic                 out_acc;

  xmpl_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign out_acc = (state_q == StUnload) && fft_out_valid_i && out_ready_i;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    winner_d  = winner_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    start_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d   = StLoad;
          gnt_d     = arb_gnt;
          winner_d  = arb_idx;
          beat_d    = '0;
          timeout_d = 1'b0;
          start_d   = 1'b1;
        end
      end

      StLoad: begin
        if (in_valid_i) begin
          if (beat_q == BeatLast) begin
            beat_d    = '0;
            tmo_cnt_d = '0;
            state_d   = StWait;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end

      StWait: begin
        // A done arriving on the terminal count still wins over the timeout.
        if (fft_done_i) begin
          tmo_cnt_d = '0;
          state_d   = StUnload;
        end else if (tmo_cnt_q == TmoLast) begin
          tmo_cnt_d = '0;
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end

      StUnload: begin
        if (out_acc) begin
          if (beat_q == BeatLast) begin
            beat_d  = '0;
            gnt_d   = '0;
            ptr_d   = (winner_q == IdLast) ? '0 : winner_q + ID_W'(1);
            state_d = StIdle;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      winner_q  <= '0;
      ptr_q     <= '0;
      beat_q    <= '0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      winner_q  <= winner_d;
      ptr_q     <= ptr_d;
      beat_q    <= beat_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
    end
  end

  // Both data paths are pure passthroughs, gated so every output is 0 outside its phase.
  always_comb begin
    gnt_o           = gnt_q;
    busy_o          = (state_q != StIdle);
    fft_en_o        = (state_q != StIdle);
    fft_start_o     = start_q;
    timeout_o       = timeout_q;
    in_ready_o      = 1'b0;
    fft_in_valid_o  = 1'b0;
    fft_in_data_o   = '0;
    fft_out_ready_o = 1'b0;
    out_valid_o     = 1'b0;
    out_data_o      = '0;
    out_last_o      = 1'b0;
    out_id_o        = '0;

    if (state_q == StLoad) begin
      in_ready_o     = 1'b1;
      fft_in_valid_o = in_valid_i;
      fft_in_data_o  = in_data_i;
    end

    if (state_q == StUnload) begin
      fft_out_ready_o = out_ready_i;
      out_valid_o     = fft_out_valid_i;
      out_data_o      = fft_out_data_i;
      out_last_o      = (beat_q == BeatLast);
      out_id_o        = winner_q;
    end
  end

endmodule

// File: tb/tb_xmpl_fft_sched.sv
// Randomized scoreboard bench for xmpl_fft_sched with a frame-level RR reference model.
module tb_xmpl_fft_sched;

  localparam int unsigned NR = 2;
  localparam int unsigned SW = 16;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned IW = $clog2(NR);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [NR-1:0] req_i;
  logic [NR-1:0] gnt_o;
  logic          in_valid_i;
  logic [SW-1:0] in_data_i;
  logic          in_ready_o;
  logic          fft_en_o;
  logic          fft_start_o;
  logic          fft_in_valid_o;
  logic [SW-1:0] fft_in_data_o;
  logic          fft_done_i;
  logic          fft_out_valid_i;
  logic [SW-1:0] fft_out_data_i;
  logic          fft_out_ready_o;
  logic          out_valid_o;
  logic [SW-1:0] out_data_o;
  logic          out_last_o;
  logic [IW-1:0] out_id_o;
  logic          out_ready_i;
  logic          busy_o;
  logic          timeout_o;

  xmpl_fft_sched #(
    .NUM_REQ   (NR),
    .SAMPLE_W  (SW),
    .FRAME_LEN (FL),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_i           (req_i),
    .gnt_o           (gnt_o),
    .in_valid_i      (in_valid_i),
    .in_data_i       (in_data_i),
    .in_ready_o      (in_ready_o),
    .fft_en_o        (fft_en_o),
    .fft_start_o     (fft_start_o),
    .fft_in_valid_o  (fft_in_valid_o),
    .fft_in_data_o   (fft_in_data_o),
    .fft_done_i      (fft_done_i),
    .fft_out_valid_i (fft_out_valid_i),
    .fft_out_data_i  (fft_out_data_i),
    .fft_out_ready_o (fft_out_ready_o),
    .out_valid_o     (out_valid_o),
    .out_data_o      (out_data_o),
    .out_last_o      (out_last_o),
    .out_id_o        (out_id_o),
    .out_ready_i     (out_ready_i),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [SW-1:0] data;
    logic          last;
    int            id;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   model_ptr;
  bit   model_tmo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First requester at or after p, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return 0;
  endfunction

  // Monitor: every accepted output beat must match the next expected entry.
  always @(negedge clk_i) begin : mon
    exp_t e;
    #2;
    if (out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_beat", 64'(out_valid_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_data", 64'(out_data_o), 64'(e.data));
        check("out_last", 64'(out_last_o), 64'(e.last));
        check("out_id", 64'(out_id_o), 64'(e.id));
      end
    end
  end

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input logic [NR-1:0] req, input int done_dly, input bit do_tmo,
                           input bit drop_req, input int rdy_mode);
    int            w;
    logic [NR-1:0] w_oh;
    int            acc;
    int            cyc;
    int            k;
    bit            done_seen;
    logic [SW-1:0] res [FL];

    w    = rr_pick(req, model_ptr);
    w_oh = NR'(1) << w;

    @(negedge clk_i);
    req_i           = req;
    in_valid_i      = 1'b0;
    fft_done_i      = 1'b0;
    fft_out_valid_i = 1'b0;
    out_ready_i     = 1'($urandom_range(0, 1));
    #1;
    check("idle_gnt", 64'(gnt_o), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_timeout_flag", 64'(timeout_o), 64'(model_tmo));

    acc = 0;
    cyc = 0;
    while (acc < FL && cyc < 8 * FL) begin
      @(negedge clk_i);
      if (drop_req) req_i = '0;
      in_valid_i = ($urandom_range(0, 3) != 0);
      in_data_i  = SW'($urandom);
      fft_done_i = 1'($urandom_range(0, 1));
      #1;
      check("load_start", 64'(fft_start_o), 64'(cyc == 0));
      check("load_gnt", 64'(gnt_o), 64'(w_oh));
      check("load_en", 64'(fft_en_o), 64'd1);
      check("load_in_ready", 64'(in_ready_o), 64'd1);
      check("load_in_valid", 64'(fft_in_valid_o), 64'(in_valid_i));
      if (in_valid_i) check("load_in_data", 64'(fft_in_data_o), 64'(in_data_i));
      if (cyc == 0) check("timeout_clr_on_grant", 64'(timeout_o), 64'd0);
      if (in_valid_i && in_ready_o) acc++;
      cyc++;
    end
    if (acc < FL) check("load_beats", 64'(acc), 64'(FL));

    k         = 0;
    done_seen = 1'b0;
    while (!done_seen && k < TO) begin
      @(negedge clk_i);
      in_valid_i      = 1'($urandom_range(0, 1));
      fft_done_i      = !do_tmo && (k == done_dly);
      fft_out_valid_i = 1'($urandom_range(0, 1));
      out_ready_i     = 1'b1;
      #1;
      check("wait_busy", 64'(busy_o), 64'd1);
      check("wait_en", 64'(fft_en_o), 64'd1);
      check("wait_gnt", 64'(gnt_o), 64'(w_oh));
      check("wait_in_valid", 64'(fft_in_valid_o), 64'd0);
      check("wait_out_valid", 64'(out_valid_o), 64'd0);
      done_seen = fft_done_i;
      k++;
    end

    if (do_tmo) begin
      @(negedge clk_i);
      req_i           = '0;
      in_valid_i      = 1'b0;
      fft_done_i      = 1'b0;
      fft_out_valid_i = 1'b1;
      #1;
      check("tmo_flag", 64'(timeout_o), 64'd1);
      check("tmo_en", 64'(fft_en_o), 64'd0);
      check("tmo_busy", 64'(busy_o), 64'd0);
      check("tmo_gnt", 64'(gnt_o), 64'd0);
      check("tmo_out_valid", 64'(out_valid_o), 64'd0);
      model_tmo = 1'b1;
      return;
    end

    for (int i = 0; i < FL; i++) begin
      res[i] = SW'($urandom);
      sb_q.push_back('{data: res[i], last: (i == FL - 1), id: w});
    end

    acc = 0;
    cyc = 0;
    while (acc < FL && cyc < 16 * FL) begin
      @(negedge clk_i);
      fft_done_i      = 1'($urandom_range(0, 1));
      in_valid_i      = 1'($urandom_range(0, 1));
      fft_out_valid_i = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      fft_out_data_i  = res[acc];
      case (rdy_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("unload_ready_mirror", 64'(fft_out_ready_o), 64'(out_ready_i));
      check("unload_gnt", 64'(gnt_o), 64'(w_oh));
      check("unload_en", 64'(fft_en_o), 64'd1);
      check("unload_timeout_flag", 64'(timeout_o), 64'd0);
      check("unload_in_ready", 64'(in_ready_o), 64'd0);
      if (fft_out_valid_i && out_ready_i) acc++;
      cyc++;
    end
    if (acc < FL) check("unload_beats", 64'(acc), 64'(FL));
    model_ptr = (w + 1) % NR;
  endtask

  task automatic reset_mid_load();
    int w;
    w = rr_pick(2'b11, model_ptr);
    @(negedge clk_i);
    req_i      = 2'b11;
    in_valid_i = 1'b0;
    fft_done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      in_valid_i = 1'b1;
      in_data_i  = SW'($urandom);
      #1;
      check("pre_reset_gnt", 64'(gnt_o), 64'(NR'(1) << w));
    end
    @(negedge clk_i);
    reset_i         = 1'b1;
    fft_out_valid_i = 1'b1;
    out_ready_i     = 1'b1;
    @(negedge clk_i);
    #1;
    check("mid_reset_gnt", 64'(gnt_o), 64'd0);
    check("mid_reset_outs", 64'({busy_o, in_ready_o, fft_en_o, fft_start_o, fft_in_valid_o,
                                 fft_out_ready_o, out_valid_o, out_last_o, timeout_o}), 64'd0);
    @(negedge clk_i);
    reset_i         = 1'b0;
    req_i           = '0;
    in_valid_i      = 1'b0;
    fft_out_valid_i = 1'b0;
    model_ptr       = 0;
    model_tmo       = 1'b0;
  endtask

  initial begin
    reset_i         = 1'b1;
    req_i           = '0;
    in_valid_i      = 1'b0;
    in_data_i       = '0;
    fft_done_i      = 1'b0;
    fft_out_valid_i = 1'b0;
    fft_out_data_i  = '0;
    out_ready_i     = 1'b0;
    model_ptr       = 0;
    model_tmo       = 1'b0;

    repeat (3) @(negedge clk_i);
    #1;
    check("reset_gnt", 64'(gnt_o), 64'd0);
    check("reset_outs", 64'({busy_o, in_ready_o, fft_en_o, fft_start_o, out_valid_o,
                             timeout_o}), 64'd0);
    reset_i = 1'b0;

    for (int f = 0; f < 4; f++) run_frame(2'b11, $urandom_range(0, 8), 1'b0, 1'b0, 2);
    run_frame(2'b01, 5, 1'b0, 1'b1, 0);
    run_frame(2'b10, $urandom_range(0, 6), 1'b0, 1'b0, 1);
    run_frame(2'b01, 0, 1'b1, 1'b0, 0);
    run_frame(2'b11, TO - 1, 1'b0, 1'b0, 0);
    reset_mid_load();
    run_frame(2'b11, 3, 1'b0, 1'b0, 0);
    for (int f = 0; f < 6; f++) begin
      run_frame(NR'($urandom_range(1, 3)), $urandom_range(0, 10), 1'b0, 1'b0, 2);
    end

    @(negedge clk_i);
    #3;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xmpl_fft_sched.md
Name: xmpl_fft_sched

Overview:
Frame scheduler that shares one xmpl_fft core between NUM_REQ requesters. It arbitrates round-robin at frame granularity and enables the core. It then streams FRAME_LEN input samples in, waits for core completion with a timeout, and streams FRAME_LEN results back tagged with the owner ID. It sits between the requester channels and the FFT datapath in the DSP core.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
SAMPLE_W, 16, sample/result width in bits
FRAME_LEN, 64, beats per frame (power of two, >=2)
TIMEOUT, 1024, max cycles in WAIT before abort
ID_W, $clog2(NUM_REQ), width of requester ID (localparam)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
req_i  in  NUM_REQ  per-requester frame request (level)
gnt_o  out  NUM_REQ  one-hot grant, held for the whole frame
in_valid_i  in  1  sample valid from granted requester
in_data_i  in  SAMPLE_W  sample data
in_ready_o  out  1  sample accepted
fft_en_o  out  1  core enable, high from LOAD to end of UNLOAD
fft_start_o  out  1  1-cycle pulse entering LOAD
fft_in_valid_o  out  1  sample beat to core
fft_in_data_o  out  SAMPLE_W  sample to core
fft_done_i  in  1  core finished computation (pulse)
fft_out_valid_i  in  1  result beat from core
fft_out_data_i  in  SAMPLE_W  result from core
fft_out_ready_o  out  1  backpressure to core
out_valid_o  out  1  result valid
out_data_o  out  SAMPLE_W  result data
out_last_o  out  1  last beat of frame
out_id_o  out  ID_W  owner of current result
out_ready_i  in  1  downstream ready
busy_o  out  1  state != IDLE
timeout_o  out  1  sticky; set on WAIT timeout, cleared at next grant

Behaviour:
- Reset:
  - State goes to IDLE; RR pointer, beat counter and timeout counter clear to 0.
  - All outputs are 0, including gnt_o, in_ready_o, fft_en_o and timeout_o.
  - A reset mid-frame aborts the frame immediately; no partial beats are emitted after reset.
- States:
  - IDLE: if any req_i, register the winner (first set bit at or after the RR pointer, wrapping) and go to LOAD the next cycle.
  - LOAD: gnt_o[winner]=1; fft_en_o=1; fft_start_o pulses on the first LOAD cycle.
    - in_ready_o=1 and fft_in_valid_o=in_valid_i, data passed combinationally.
    - The beat counter increments per accepted beat; at beat FRAME_LEN-1 go to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - On fft_done_i, go to UNLOAD.
    - If the counter reaches TIMEOUT-1 without done, set timeout_o, drop fft_en_o and go to IDLE. No results are emitted.
  - UNLOAD: out_valid_o=fft_out_valid_i; out_data_o=fft_out_data_i; fft_out_ready_o=out_ready_i; out_id_o=winner.
    - out_last_o is high on beat FRAME_LEN-1.
    - After that beat is accepted, go to IDLE, release the grant, and set the RR pointer to winner+1 mod NUM_REQ.
- Latency: grant is asserted 1 cycle after req_i is seen in IDLE. In/out data paths add zero cycles (combinational passthrough).
- fft_done_i in a state other than WAIT is ignored. Done in the same cycle as the timeout terminal count counts as done (done wins).
- A requester dropping req_i mid-frame does not end the frame; the grant persists until UNLOAD completes or timeout.
- Simultaneous requests are resolved by RR only; no requester waits more than NUM_REQ-1 frames.
- Beat counter width is $clog2(FRAME_LEN) and wraps to 0 at frame end. Counters never exceed terminal values.
- The grant is always one-hot or zero.

Decomposition:
- Package xmpl_fft_pkg:
  - state enum (IDLE, LOAD, WAIT, UNLOAD)
  - default SAMPLE_W / FRAME_LEN constants
  - TIMEOUT default
- Sub-module xmpl_rr_arb: parameterised round-robin arbiter. Takes req vector and pointer; returns one-hot grant and index; purely combinational.
- The FSM, counters and muxing live in xmpl_fft_sched.

Test Plan:
- Single request: req_i=2'b01, FRAME_LEN=4, core done 5 cycles after the last input.
  - gnt_o=01 one cycle later; fft_start_o is a 1-cycle pulse.
  - 4 inputs are forwarded; 4 outputs come out with out_id_o=0 and out_last_o on beat 3.
  - busy_o returns to 0.
- Contention: req_i=2'b11 held for 4 frames -> grants alternate 0,1,0,1; out_id_o matches each frame's grant.
- Backpressure: during UNLOAD, out_ready_i toggles 1,0,0,1.
  - fft_out_ready_o mirrors out_ready_i.
  - No beat is lost or duplicated; the frame still ends on beat FRAME_LEN-1.
- Timeout: TIMEOUT=16, fft_done_i never asserted.
  - After 16 WAIT cycles: timeout_o=1, fft_en_o=0, state IDLE, no out_valid_o.
  - timeout_o clears on the next grant.
- Reset mid-LOAD: assert reset_i after beat 2.
  - Next cycle all outputs are 0 and gnt_o=0.
  - A new request restarts from beat 0 with the RR pointer at 0.
- Done/timeout collision: fft_done_i on the terminal timeout cycle -> UNLOAD entered, timeout_o stays 0.
